// File: rtl/button_event_decoder_pkg.sv
// Shared event codes and FSM state encoding for the button event decoder.
package button_event_pkg;

   typedef logic [1:0] ev_code_t;

   localparam ev_code_t EV_PRESS   = 2'd0;
   localparam ev_code_t EV_RELEASE = 2'd1;
   localparam ev_code_t EV_LONG    = 2'd2;
   localparam ev_code_t EV_REPEAT  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHORT = 2'd1,
      LONG  = 2'd2
   } state_t;

endpackage

// File: rtl/button_event_decoder_if.sv
// Valid/ack event handshake between the decoder and its consumer FSM.
interface button_event_if;
   import button_event_pkg::*;

   logic     event_valid;
   ev_code_t event_code;
   logic     event_ack;

   modport master (
      output event_valid,
      output event_code,
      input  event_ack
   );

   modport slave (
      input  event_valid,
      input  event_code,
      output event_ack
   );

endinterface

// File: rtl/button_event_decoder_event_slot.sv
// One-deep event holding register with a sticky overrun flag for dropped events.
module event_slot
   import button_event_pkg::*;
(
   input  logic     clk,
   input  logic     reset_n,
   input  logic     load,
   input  ev_code_t load_code,
   input  logic     overrun_clr,
   button_event_if.master evt,
   output logic     overrun
);

   logic free;
   logic drop;

   // An ack on the same edge frees the slot for the incoming event.
   assign free = ~evt.event_valid | evt.event_ack;
   assign drop = load & ~free;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         evt.event_valid <= 1'b0;
         evt.event_code  <= EV_PRESS;
         overrun         <= 1'b0;
      end else begin
         if (load && free) begin
            evt.event_valid <= 1'b1;
            evt.event_code  <= load_code;
         end else if (evt.event_ack) begin
            evt.event_valid <= 1'b0;
         end

         if (drop) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into PRESS/RELEASE/LONG/REPEAT events.
//   state | meaning
//   IDLE  | button released or decoder disabled
//   SHORT | pressed, counting towards the long-press threshold
//   LONG  | long press reached, counting auto-repeat intervals
module button_event_decoder
   import button_event_pkg::*;
#(
   parameter int CNT_W         = 26,
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic btn_level,
   button_event_if.master evt,
   output logic held,
   output logic overrun,
   input  logic overrun_clr
);

   localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             btn_q;
   logic             rise;
   logic             fall;
   logic             tc_long;
   logic             tc_repeat;
   logic             ev_fire;
   ev_code_t         ev_code;

   assign rise      = btn_level & ~btn_q;
   assign fall      = ~btn_level & btn_q;
   assign tc_long   = (cnt == LONG_TC);
   assign tc_repeat = (cnt == REPEAT_TC);

   // Release always beats a terminal count landing on the same edge.
   always_comb begin
      ev_fire = 1'b0;
      ev_code = EV_PRESS;
      if (enable) begin
         case (state)
            IDLE: begin
               if (rise) begin
                  ev_fire = 1'b1;
                  ev_code = EV_PRESS;
               end
            end
            SHORT: begin
               if (fall) begin
                  ev_fire = 1'b1;
                  ev_code = EV_RELEASE;
               end else if (tc_long) begin
                  ev_fire = 1'b1;
                  ev_code = EV_LONG;
               end
            end
            LONG: begin
               if (fall) begin
                  ev_fire = 1'b1;
                  ev_code = EV_RELEASE;
               end else if (tc_repeat) begin
                  ev_fire = 1'b1;
                  ev_code = EV_REPEAT;
               end
            end
            default: begin
               ev_fire = 1'b0;
               ev_code = EV_PRESS;
            end
         endcase
      end
   end

   // btn_q tracks even while disabled, so re-enabling with the button down is silent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         btn_q <= 1'b0;
         held  <= 1'b0;
      end else begin
         btn_q <= btn_level;
         if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
            held  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (rise) begin
                     state <= SHORT;
                     cnt   <= '0;
                     held  <= 1'b1;
                  end
               end
               SHORT: begin
                  if (fall) begin
                     state <= IDLE;
                     cnt   <= '0;
                     held  <= 1'b0;
                  end else if (tc_long) begin
                     state <= LONG;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               LONG: begin
                  if (fall) begin
                     state <= IDLE;
                     cnt   <= '0;
                     held  <= 1'b0;
                  end else if (tc_repeat) begin
                     cnt <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  held  <= 1'b0;
               end
            endcase
         end
      end
   end

   event_slot u_slot (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (ev_fire),
      .load_code   (ev_code),
      .overrun_clr (overrun_clr),
      .evt         (evt),
      .overrun     (overrun)
   );

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed vector bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event_decoder;

   logic clk;
   logic reset_n;
   logic enable;
   logic btn_level;
   logic held;
   logic overrun;
   logic overrun_clr;

   int n_vec;
   int n_err;

   button_event_if bus ();

   button_event_decoder #(
      .CNT_W         (4),
      .LONG_CYCLES   (8),
      .REPEAT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .btn_level   (btn_level),
      .evt         (bus),
      .held        (held),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       btn;
      logic       ack;
      logic       clr;
      logic       vld;
      logic [1:0] code;
      logic       hld;
      logic       ovr;
   } vec_t;

   vec_t vt[28];

   function automatic vec_t mk(input logic en, btn, ack, clr, vld,
                               input logic [1:0] code, input logic hld, ovr);
      vec_t v;
      v.en = en; v.btn = btn; v.ack = ack; v.clr = clr;
      v.vld = vld; v.code = code; v.hld = hld; v.ovr = ovr;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   int         ev_cyc[$];
   logic [1:0] ev_cd[$];
   int         exp_cyc[5];
   logic [1:0] exp_cd[5];

   initial begin
      n_vec = 0;
      n_err = 0;
      reset_n = 1'b0;
      enable = 1'b1;
      btn_level = 1'b0;
      overrun_clr = 1'b0;
      bus.event_ack = 1'b0;

      //            en btn ack clr  vld code hld ovr
      vt[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0);
      vt[1]  = mk(1, 1, 0, 0,  1, 0, 1, 0);
      vt[2]  = mk(1, 1, 1, 0,  0, 0, 1, 0);
      vt[3]  = mk(1, 1, 0, 0,  0, 0, 1, 0);
      vt[4]  = mk(1, 1, 0, 0,  0, 0, 1, 0);
      vt[5]  = mk(1, 0, 0, 0,  1, 1, 0, 0);
      vt[6]  = mk(1, 0, 1, 0,  0, 0, 0, 0);
      vt[7]  = mk(1, 1, 0, 0,  1, 0, 1, 0);
      vt[8]  = mk(1, 1, 0, 0,  1, 0, 1, 0);
      vt[9]  = mk(1, 0, 0, 0,  1, 0, 0, 1);
      vt[10] = mk(1, 0, 0, 0,  1, 0, 0, 1);
      vt[11] = mk(1, 0, 0, 1,  1, 0, 0, 0);
      vt[12] = mk(1, 0, 1, 0,  0, 0, 0, 0);
      vt[13] = mk(1, 1, 0, 0,  1, 0, 1, 0);
      vt[14] = mk(1, 0, 0, 1,  1, 0, 0, 1);
      vt[15] = mk(1, 0, 1, 1,  0, 0, 0, 0);
      vt[16] = mk(1, 1, 0, 0,  1, 0, 1, 0);
      vt[17] = mk(1, 0, 1, 0,  1, 1, 0, 0);
      vt[18] = mk(1, 0, 1, 0,  0, 0, 0, 0);
      vt[19] = mk(0, 1, 0, 0,  0, 0, 0, 0);
      vt[20] = mk(0, 1, 0, 0,  0, 0, 0, 0);
      vt[21] = mk(1, 1, 0, 0,  0, 0, 0, 0);
      vt[22] = mk(1, 1, 0, 0,  0, 0, 0, 0);
      vt[23] = mk(1, 0, 0, 0,  0, 0, 0, 0);
      vt[24] = mk(1, 1, 0, 0,  1, 0, 1, 0);
      vt[25] = mk(0, 1, 0, 0,  1, 0, 0, 0);
      vt[26] = mk(1, 1, 1, 0,  0, 0, 0, 0);
      vt[27] = mk(1, 0, 0, 0,  0, 0, 0, 0);

      #12;
      check("rst_valid",   0, int'(bus.event_valid), 0);
      check("rst_held",    0, int'(held), 0);
      check("rst_overrun", 0, int'(overrun), 0);
      reset_n = 1'b1;

      for (int i = 0; i < 28; i++) begin
         enable        = vt[i].en;
         btn_level     = vt[i].btn;
         bus.event_ack = vt[i].ack;
         overrun_clr   = vt[i].clr;
         @(posedge clk);
         #1;
         check("valid",   i, int'(bus.event_valid), int'(vt[i].vld));
         check("held",    i, int'(held), int'(vt[i].hld));
         check("overrun", i, int'(overrun), int'(vt[i].ovr));
         if (vt[i].vld)
            check("code", i, int'(bus.event_code), int'(vt[i].code));
      end
      bus.event_ack = 1'b0;
      overrun_clr   = 1'b0;

      // Long hold: 20 cycles pressed, consumer acks the cycle after each event.
      exp_cyc[0] = 1;  exp_cd[0] = 2'd0;
      exp_cyc[1] = 9;  exp_cd[1] = 2'd2;
      exp_cyc[2] = 13; exp_cd[2] = 2'd3;
      exp_cyc[3] = 17; exp_cd[3] = 2'd3;
      exp_cyc[4] = 21; exp_cd[4] = 2'd1;
      for (int c = 1; c <= 24; c++) begin
         btn_level = (c <= 20);
         @(posedge clk);
         #1;
         if (bus.event_valid) begin
            ev_cyc.push_back(c);
            ev_cd.push_back(bus.event_code);
            bus.event_ack = 1'b1;
         end else begin
            bus.event_ack = 1'b0;
         end
      end
      bus.event_ack = 1'b0;
      check("long_ev_count", 0, ev_cyc.size(), 5);
      for (int k = 0; k < 5 && k < ev_cyc.size(); k++) begin
         check("long_ev_cycle", k, ev_cyc[k], exp_cyc[k]);
         check("long_ev_code",  k, int'(ev_cd[k]), int'(exp_cd[k]));
      end

      // Async reset in the middle of a LONG hold with a pending event and overrun set.
      btn_level = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      check("pre_rst_held",    0, int'(held), 1);
      check("pre_rst_valid",   0, int'(bus.event_valid), 1);
      check("pre_rst_overrun", 0, int'(overrun), 1);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_rst_valid",   0, int'(bus.event_valid), 0);
      check("async_rst_held",    0, int'(held), 0);
      check("async_rst_overrun", 0, int'(overrun), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_valid",   0, int'(bus.event_valid), 1);
      check("post_rst_code",    0, int'(bus.event_code), 0);
      check("post_rst_held",    0, int'(held), 1);
      check("post_rst_overrun", 0, int'(overrun), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
